// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage constants and exception codes
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES  = 32'd16384;
    localparam logic [31:0] EXC_PC    = 32'h0000_4180;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // ExcCode reported to CP0 for an instruction-fetch address error
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// rtl/fetch_stage_fd_pipe_reg.sv - F/D pipeline register with enable and clear
import fetch_stage_pkg::*;

module fd_pipe_reg (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    input  logic        fetch_bd,
    input  logic        fetch_adel,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic        d_bd,
    output logic        d_exc_adel
);

    // Clear inserts a bubble (NOP, not valid); enable captures the fetched word
    always_ff @(posedge clk) begin
        if (clr) begin
            d_pc       <= 32'h0;
            d_instr    <= NOP;
            d_valid    <= 1'b0;
            d_bd       <= 1'b0;
            d_exc_adel <= 1'b0;
        end else if (en) begin
            d_pc       <= fetch_pc;
            d_instr    <= fetch_instr;
            d_valid    <= 1'b1;
            d_bd       <= fetch_bd;
            d_exc_adel <= fetch_adel;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: PC register, AdEL check, F/D register
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] IM_BASE_P  = IM_BASE,
    parameter logic [31:0] IM_BYTES_P = IM_BYTES,
    parameter logic [31:0] EXC_PC_P   = EXC_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] next_pc,
    input  logic [31:0] im_rdata,
    input  logic        d_is_ctrl,
    output logic [31:0] f_pc,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic        d_bd,
    output logic        d_exc_adel
);

    // Window end in 33 bits so a window touching the top of memory cannot wrap
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE_P} + {1'b0, IM_BYTES_P};

    logic        adel;
    logic [31:0] fetch_instr;

    // Address error on misalignment or any fetch outside the instruction window
    always_comb begin
        adel = (f_pc[1:0] != 2'b00)
            || (f_pc < IM_BASE_P)
            || ({1'b0, f_pc} >= IM_LIMIT);
        fetch_instr = adel ? NOP : im_rdata;
    end

    // PC register: reset > flush > stall > load next_pc unmodified
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc <= RESET_PC_P;
        end else if (flush) begin
            f_pc <= EXC_PC_P;
        end else if (!stall) begin
            f_pc <= next_pc;
        end
    end

    fd_pipe_reg u_fd (
        .clk         (clk),
        .clr         (reset | flush),
        .en          (~stall),
        .fetch_pc    (f_pc),
        .fetch_instr (fetch_instr),
        .fetch_bd    (d_is_ctrl),
        .fetch_adel  (adel),
        .d_pc        (d_pc),
        .d_instr     (d_instr),
        .d_valid     (d_valid),
        .d_bd        (d_bd),
        .d_exc_adel  (d_exc_adel)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with reference model
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] next_pc;
    logic [31:0] im_rdata;
    logic        d_is_ctrl;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        d_bd;
    logic        d_exc_adel;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .next_pc    (next_pc),
        .im_rdata   (im_rdata),
        .d_is_ctrl  (d_is_ctrl),
        .f_pc       (f_pc),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_valid    (d_valid),
        .d_bd       (d_bd),
        .d_exc_adel (d_exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic        d_valid;
        logic        d_bd;
        logic        d_exc_adel;
    } obs_t;

    obs_t exp_q[$];
    obs_t model;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Legal fetch: word aligned and inside [0x3000, 0x7000)
    function automatic bit fetch_ok(input logic [31:0] pc);
        longint unsigned a;
        a = longint'(pc);
        return (a % 4 == 0) && (a >= 64'h3000) && (a < 64'h3000 + 64'd16384);
    endfunction

    // Drive one cycle of inputs and record what the outputs must be after the edge
    task automatic step(input logic rst, input logic fl, input logic st,
                        input logic [31:0] npc, input logic [31:0] rd, input logic ctrl);
        @(negedge clk);
        reset = rst; flush = fl; stall = st;
        next_pc = npc; im_rdata = rd; d_is_ctrl = ctrl;
        if (rst || fl) begin
            model.f_pc = rst ? 32'h3000 : 32'h4180;
            model.d_pc = 0; model.d_instr = 0;
            model.d_valid = 0; model.d_bd = 0; model.d_exc_adel = 0;
        end else if (!st) begin
            model.d_exc_adel = !fetch_ok(model.f_pc);
            model.d_instr    = model.d_exc_adel ? 32'h0 : rd;
            model.d_pc       = model.f_pc;
            model.d_valid    = 1'b1;
            model.d_bd       = ctrl;
            model.f_pc       = npc;
        end
        exp_q.push_back(model);
    endtask

    task automatic adv(input logic [31:0] npc, input logic [31:0] rd);
        step(1'b0, 1'b0, 1'b0, npc, rd, 1'b0);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge compare DUT outputs against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("f_pc",       f_pc,              e.f_pc);
            check("d_pc",       d_pc,              e.d_pc);
            check("d_instr",    d_instr,           e.d_instr);
            check("d_valid",    {31'b0, d_valid},  {31'b0, e.d_valid});
            check("d_bd",       {31'b0, d_bd},     {31'b0, e.d_bd});
            check("d_exc_adel", {31'b0, d_exc_adel}, {31'b0, e.d_exc_adel});
        end
    end

    logic [31:0] edge_pcs [6];

    initial begin
        edge_pcs[0] = 32'h0000_2FFC; edge_pcs[1] = 32'h0000_6FFC;
        edge_pcs[2] = 32'h0000_7000; edge_pcs[3] = 32'hFFFF_FFFC;
        edge_pcs[4] = 32'h0000_3001; edge_pcs[5] = 32'h0000_0000;

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        next_pc = 32'h0; im_rdata = 32'h0; d_is_ctrl = 1'b0;
        model.f_pc = 0; model.d_pc = 0; model.d_instr = 0;
        model.d_valid = 0; model.d_bd = 0; model.d_exc_adel = 0;

        // Reset held two cycles
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("reset_f_pc", f_pc, 32'h3000);
        check("reset_d_valid", {31'b0, d_valid}, 32'h0);

        // Sequential advance
        adv(32'h3004, 32'h2401_0001);
        settle();
        check("adv_f_pc", f_pc, 32'h3004);
        check("adv_d_pc", d_pc, 32'h3000);
        check("adv_d_instr", d_instr, 32'h2401_0001);

        // Stall three cycles with next_pc=0x3010, then release
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'h3010, $urandom, 1'b0);
        settle();
        check("stall_f_pc", f_pc, 32'h3004);
        check("stall_d_pc", d_pc, 32'h3000);
        adv(32'h3010, 32'h1111_2222);
        settle();
        check("unstall_f_pc", f_pc, 32'h3010);

        // Misaligned then out-of-window fetch
        adv(32'h3002, 32'h3333_4444);
        adv(32'h7000, 32'h5555_6666);
        settle();
        check("mis_adel", {31'b0, d_exc_adel}, 32'h1);
        check("mis_d_pc", d_pc, 32'h3002);
        check("mis_d_instr", d_instr, 32'h0);
        adv(32'h3008, 32'h7777_8888);
        settle();
        check("oor_adel", {31'b0, d_exc_adel}, 32'h1);
        check("oor_d_pc", d_pc, 32'h7000);

        // Delay slot tagging
        step(1'b0, 1'b0, 1'b0, 32'h300C, 32'h1000_0003, 1'b1);
        settle();
        check("bd_d_pc", d_pc, 32'h3008);
        check("bd_set", {31'b0, d_bd}, 32'h1);
        adv(32'h3020, 32'h0000_0000);
        settle();
        check("bd_clear", {31'b0, d_bd}, 32'h0);

        // Flush with simultaneous stall at f_pc=0x3020
        step(1'b0, 1'b1, 1'b1, 32'h3024, 32'hDEAD_BEEF, 1'b0);
        settle();
        check("flush_f_pc", f_pc, 32'h4180);
        check("flush_d_valid", {31'b0, d_valid}, 32'h0);
        check("flush_d_instr", d_instr, 32'h0);
        adv(32'h4184, 32'hCAFE_0001);
        settle();
        check("post_flush_d_pc", d_pc, 32'h4180);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            logic [31:0] npc;
            sel = $urandom_range(99);
            if (sel < 70)      npc = model.f_pc + 32'd4;
            else if (sel < 85) npc = 32'h3000 + ($urandom_range(4095) << 2);
            else if (sel < 95) npc = edge_pcs[$urandom_range(5)];
            else               npc = $urandom;
            step($urandom_range(99) < 2, $urandom_range(99) < 5,
                 $urandom_range(99) < 20, npc, $urandom, $urandom_range(99) < 20);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
